// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: program-memory port, fetch control, redirect from
// execute and the decode handshake, with the fetch stage as master.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_data;
    logic               fetch_en;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;

    modport master (
        output pm_addr, id_valid, id_instr, id_pc,
        input  pm_data, fetch_en, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  pm_addr, id_valid, id_instr, id_pc,
        output pm_data, fetch_en, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC-driven program-memory read, unconditional-JMP folding,
// execute redirects and a 2-entry {instr, pc} queue towards decode.
module instruction_fetch #(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 16,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    instruction_fetch_if.master            fif,
    output logic [$clog2(BUF_DEPTH+1)-1:0] dbg_count
);
    localparam int COUNT_W = $clog2(BUF_DEPTH + 1);

    // Decode handshake: an entry transfers on any rising edge where
    // id_valid && id_ready; while id_valid && !id_ready the presented entry is
    // held stable, and only rst or redirect_valid may withdraw it.

    logic [ADDR_W-1:0]  pc, pc_nxt;
    logic [COUNT_W-1:0] count, count_nxt;
    logic [INSTR_W-1:0] head_instr, head_instr_nxt, tail_instr, tail_instr_nxt;
    logic [ADDR_W-1:0]  head_pc, head_pc_nxt, tail_pc, tail_pc_nxt;
    logic               valid, full, pop, push, is_jmp, can_fetch;

    assign valid     = (count != '0);
    assign full      = (count == COUNT_W'(BUF_DEPTH));
    assign pop       = valid && fif.id_ready;
    assign is_jmp    = (fif.pm_data[INSTR_W-1:8] == '0);
    assign can_fetch = fif.fetch_en && (!full || pop);

    always_comb begin
        push           = 1'b0;
        pc_nxt         = pc;
        count_nxt      = count;
        head_instr_nxt = head_instr;
        head_pc_nxt    = head_pc;
        tail_instr_nxt = tail_instr;
        tail_pc_nxt    = tail_pc;

        if (fif.redirect_valid) begin
            // Flush; a same-cycle pop has already been handed to decode.
            pc_nxt    = fif.redirect_pc;
            count_nxt = '0;
        end else begin
            if (can_fetch) begin
                if (is_jmp) begin
                    pc_nxt = fif.pm_data[ADDR_W-1:0];
                end else begin
                    push   = 1'b1;
                    pc_nxt = pc + ADDR_W'(1);
                end
            end

            case ({push, pop})
                2'b10: begin
                    if (count == '0) begin
                        head_instr_nxt = fif.pm_data;
                        head_pc_nxt    = pc;
                    end else begin
                        tail_instr_nxt = fif.pm_data;
                        tail_pc_nxt    = pc;
                    end
                    count_nxt = count + COUNT_W'(1);
                end
                2'b01: begin
                    head_instr_nxt = tail_instr;
                    head_pc_nxt    = tail_pc;
                    count_nxt      = count - COUNT_W'(1);
                end
                2'b11: begin
                    if (count == COUNT_W'(1)) begin
                        head_instr_nxt = fif.pm_data;
                        head_pc_nxt    = pc;
                    end else begin
                        head_instr_nxt = tail_instr;
                        head_pc_nxt    = tail_pc;
                        tail_instr_nxt = fif.pm_data;
                        tail_pc_nxt    = pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= ADDR_W'(RESET_PC);
            count      <= '0;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
        end else begin
            pc         <= pc_nxt;
            count      <= count_nxt;
            head_instr <= head_instr_nxt;
            head_pc    <= head_pc_nxt;
            tail_instr <= tail_instr_nxt;
            tail_pc    <= tail_pc_nxt;
        end
    end

    assign fif.pm_addr  = pc;
    assign fif.id_valid = valid;
    assign fif.id_instr = valid ? head_instr : '0;
    assign fif.id_pc    = valid ? head_pc : '0;
    assign dbg_count    = count;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: straight-line, backpressure, JMP fold,
// redirect, wrap-around, fetch_en gating and mid-run reset.
module tb_instruction_fetch;
    logic        clk;
    logic        rst;
    logic [1:0]  dbg_count;
    logic [15:0] mem [256];
    logic [7:0]  exp_q [$];
    int          errors;
    int          checks;

    instruction_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instruction_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0), .BUF_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .fif       (bus),
        .dbg_count (dbg_count)
    );

    assign bus.pm_data = mem[bus.pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds rst over two rising edges; returns at a falling edge with rst high.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst                = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.id_ready       = ready;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (bus.pm_addr !== 8'h00) begin errors++; $display("FAIL reset_pm_addr got=%0h exp=0", bus.pm_addr); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%0b exp=0", bus.id_valid); end
        checks++; if (bus.id_instr !== 16'h0000) begin errors++; $display("FAIL reset_id_instr got=%0h exp=0", bus.id_instr); end
        checks++; if (bus.id_pc !== 8'h00) begin errors++; $display("FAIL reset_id_pc got=%0h exp=0", bus.id_pc); end
    endtask

    task automatic test_straight_line();
        logic [15:0] exp_instr [3];
        exp_instr[0] = 16'h60FF; exp_instr[1] = 16'h61FE; exp_instr[2] = 16'h62FD;
        do_reset(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'(i) || bus.id_instr !== exp_instr[i]) begin
                errors++;
                $display("FAIL straight_line[%0d] got v=%0b pc=%0h instr=%0h exp v=1 pc=%0h instr=%0h",
                         i, bus.id_valid, bus.id_pc, bus.id_instr, i, exp_instr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || dbg_count !== 2'd1) begin
            errors++; $display("FAIL bp_first got v=%0b pc=%0h cnt=%0d exp v=1 pc=0 cnt=1", bus.id_valid, bus.id_pc, dbg_count); end
        repeat (4) @(negedge clk);
        checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", dbg_count); end
        checks++; if (bus.pm_addr !== 8'h02) begin errors++; $display("FAIL bp_pm_addr got=%0h exp=2", bus.pm_addr); end
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || bus.id_instr !== 16'h60FF) begin
            errors++; $display("FAIL bp_stable got v=%0b pc=%0h instr=%0h exp v=1 pc=0 instr=60ff", bus.id_valid, bus.id_pc, bus.id_instr); end
        exp_q = {8'h00, 8'h01, 8'h02, 8'h03};
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_q[0]) begin
                errors++; $display("FAIL bp_drain[%0d] got v=%0b pc=%0h exp v=1 pc=%0h", i, bus.id_valid, bus.id_pc, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    task automatic test_jmp_fold();
        do_reset(1'b1);
        rst                = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h07;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.id_valid !== 1'b0 || bus.pm_addr !== 8'h07) begin
            errors++; $display("FAIL jmp_start got v=%0b addr=%0h exp v=0 addr=7", bus.id_valid, bus.pm_addr); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h07 || bus.id_instr !== 16'h7102) begin
            errors++; $display("FAIL jmp_pc7 got v=%0b pc=%0h instr=%0h exp v=1 pc=7 instr=7102", bus.id_valid, bus.id_pc, bus.id_instr); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble got v=%0b pc=%0h exp v=0", bus.id_valid, bus.id_pc); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h0A || bus.id_instr !== 16'h6E01) begin
            errors++; $display("FAIL jmp_target got v=%0b pc=%0h instr=%0h exp v=1 pc=a instr=6e01", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        rst                = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h03;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dbg_count !== 2'd2 || bus.id_pc !== 8'h03) begin
            errors++; $display("FAIL redir_setup got cnt=%0d pc=%0h exp cnt=2 pc=3", dbg_count, bus.id_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h14;
        bus.id_ready       = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.id_valid !== 1'b0 || bus.pm_addr !== 8'h14) begin
            errors++; $display("FAIL redir_bubble got v=%0b addr=%0h exp v=0 addr=14", bus.id_valid, bus.pm_addr); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h14 || bus.id_instr !== 16'hA014) begin
            errors++; $display("FAIL redir_target got v=%0b pc=%0h instr=%0h exp v=1 pc=14 instr=a014", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        rst                = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hFF;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'hFF || bus.id_instr !== 16'hA0FF) begin
            errors++; $display("FAIL wrap_ff got v=%0b pc=%0h instr=%0h exp v=1 pc=ff instr=a0ff", bus.id_valid, bus.id_pc, bus.id_instr); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || bus.id_instr !== 16'h60FF) begin
            errors++; $display("FAIL wrap_00 got v=%0b pc=%0h instr=%0h exp v=1 pc=0 instr=60ff", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_fetch_en();
        do_reset(1'b1);
        rst                = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h20;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0 || bus.pm_addr !== 8'h20) begin
            errors++; $display("FAIL fen_hold got v=%0b addr=%0h exp v=0 addr=20", bus.id_valid, bus.pm_addr); end
        bus.fetch_en = 1'b1;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h20 || bus.id_instr !== 16'hA020) begin
            errors++; $display("FAIL fen_resume got v=%0b pc=%0h instr=%0h exp v=1 pc=20 instr=a020", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_reset_mid_run();
        do_reset(1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL rmid_setup got cnt=%0d exp=2", dbg_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 16'h0000 || bus.id_pc !== 8'h00 || bus.pm_addr !== 8'h00) begin
            errors++; $display("FAIL rmid_cleared got v=%0b instr=%0h pc=%0h addr=%0h exp all 0",
                               bus.id_valid, bus.id_instr, bus.id_pc, bus.pm_addr); end
        bus.id_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || bus.id_instr !== 16'h60FF) begin
            errors++; $display("FAIL rmid_restart0 got v=%0b pc=%0h instr=%0h exp v=1 pc=0 instr=60ff", bus.id_valid, bus.id_pc, bus.id_instr); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h01) begin
            errors++; $display("FAIL rmid_restart1 got v=%0b pc=%0h exp v=1 pc=1", bus.id_valid, bus.id_pc); end
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        rst                = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.id_ready       = 1'b0;
        // Background program: every word is a non-JMP tagged with its address.
        for (int i = 0; i < 256; i++) mem[i] = {8'hA0, 8'(i)};
        mem[0]  = 16'h60FF;
        mem[1]  = 16'h61FE;
        mem[2]  = 16'h62FD;
        mem[7]  = 16'h7102;
        mem[8]  = 16'h000A;
        mem[9]  = 16'h6F02;
        mem[10] = 16'h6E01;

        test_reset();
        test_straight_line();
        test_backpressure();
        test_jmp_fold();
        test_redirect_full();
        test_wrap();
        test_fetch_en();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
